cordic_job_sequencer: RTL and testbench

//  Parametrised successor to the single-shot CORDIC controller. Accepts jobs over a valid/ready

---
 rtl/cordic_job_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_cordic_job_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_job_sequencer.sv
// Job sequencer for an external CORDIC step unit and angle LUT: accepts tagged jobs,
// performs one micro-rotation per cycle, and returns the tagged result with status.
module cordic_job_sequencer #(
  parameter int W         = 32,
  parameter int IW        = 5,
  parameter int TW        = 4,
  parameter bit OV_STOP   = 1'b1,
  parameter bit Z_OV_STOP = 1'b1,
  parameter bit IRQ_RES   = 1'b1,
  parameter bit IRQ_ERR   = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          job_valid,
  output logic          job_ready,
  input  logic [W-1:0]  job_x,
  input  logic [W-1:0]  job_y,
  input  logic [W-1:0]  job_z,
  input  logic          job_mode,
  input  logic [1:0]    job_sys,
  input  logic [IW-1:0] job_iter,
  input  logic [TW-1:0] job_tag,
  input  logic          abort,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [W-1:0]  res_x,
  output logic [W-1:0]  res_y,
  output logic [W-1:0]  res_z,
  output logic [TW-1:0] res_tag,
  output logic [IW-1:0] res_iters,
  output logic [4:0]    res_status,
  output logic          irq,
  output logic [W-1:0]  cd_x_prev,
  output logic [W-1:0]  cd_y_prev,
  output logic [W-1:0]  cd_z_prev,
  output logic [IW-1:0] cd_shift,
  output logic          cd_dir,
  output logic [1:0]    cd_sys,
  output logic [W-1:0]  cd_angle,
  input  logic [W-1:0]  cd_x_res,
  input  logic [W-1:0]  cd_y_res,
  input  logic [W-1:0]  cd_z_res,
  input  logic          cd_x_ov,
  input  logic          cd_y_ov,
  input  logic          cd_z_ov,
  output logic [IW-1:0] lut_offset,
  output logic [1:0]    lut_sys,
  input  logic [W-1:0]  lut_angle
);

  // state | meaning
  // IDLE  | ready for a job
  // PRE   | quadrant correction, input check, initial shift
  // ITER  | one committed micro-rotation per cycle
  // DONE  | result held until consumed
  typedef enum logic [1:0] {IDLE, PRE, ITER, DONE} state_t;

  localparam logic [1:0] SYS_HYP  = 2'b00;
  localparam logic [1:0] SYS_CIRC = 2'b01;
  localparam logic [1:0] SYS_BAD  = 2'b11;
  localparam logic signed [W-1:0] Q_POS = {2'b01, {(W-2){1'b0}}};
  localparam logic signed [W-1:0] Q_NEG = -Q_POS;

  state_t        state_q, state_n;
  logic [W-1:0]  x_q, y_q, z_q, x_n, y_n, z_n;
  logic          mode_q, mode_n;
  logic [1:0]    sys_q, sys_n;
  logic [IW-1:0] iter_q, iter_n, count_q, count_n, shift_q, shift_n;
  logic [TW-1:0] tag_q, tag_n;
  logic          rep4_q, rep4_n, rep13_q, rep13_n;
  logic [4:0]    status_q, status_n;
  logic          irq_q, irq_n;

  logic [W:0]    y_ext, y_abs;
  logic          z_big, flip, pre_err, ov_stop, is_hyp;
  logic [4:0]    iter_status;
  logic [IW-1:0] count_inc;

  assign is_hyp  = (sys_q == SYS_HYP);
  assign y_ext   = {y_q[W-1], y_q};
  assign y_abs   = y_q[W-1] ? -y_ext : y_ext;
  assign z_big   = ($signed(z_q) > Q_POS) || ($signed(z_q) < Q_NEG);
  assign flip    = (sys_q == SYS_CIRC) && (mode_q ? z_big : x_q[W-1]);
  assign pre_err = (sys_q == SYS_BAD) || (iter_q == '0) ||
                   (is_hyp && (x_q[W-1] || (y_abs > {1'b0, x_q})));
  assign iter_status = status_q | {abort, 1'b0, cd_z_ov, cd_y_ov, cd_x_ov};
  assign ov_stop   = OV_STOP && (iter_status[0] || iter_status[1] || (Z_OV_STOP && iter_status[2]));
  assign count_inc = count_q + IW'(1);

  always_comb begin
    state_n  = state_q;
    x_n      = x_q;
    y_n      = y_q;
    z_n      = z_q;
    mode_n   = mode_q;
    sys_n    = sys_q;
    iter_n   = iter_q;
    tag_n    = tag_q;
    count_n  = count_q;
    shift_n  = shift_q;
    rep4_n   = rep4_q;
    rep13_n  = rep13_q;
    status_n = status_q;
    irq_n    = 1'b0;
    case (state_q)
      IDLE: if (job_valid) begin
        x_n      = job_x;
        y_n      = job_y;
        z_n      = job_z;
        mode_n   = job_mode;
        sys_n    = job_sys;
        iter_n   = job_iter;
        tag_n    = job_tag;
        count_n  = '0;
        status_n = '0;
        state_n  = PRE;
      end
      PRE: begin
        shift_n = is_hyp ? IW'(1) : '0;
        rep4_n  = 1'b0;
        rep13_n = 1'b0;
        if (flip) begin
          x_n = -x_q;
          y_n = -y_q;
          z_n = {~z_q[W-1], z_q[W-2:0]};
        end
        status_n = {abort, pre_err, 3'b000};
        if (pre_err || abort) begin
          state_n = DONE;
          irq_n   = IRQ_RES || (IRQ_ERR && pre_err);
        end else begin
          state_n = ITER;
        end
      end
      ITER: begin
        x_n      = cd_x_res;
        y_n      = cd_y_res;
        z_n      = cd_z_res;
        count_n  = count_inc;
        status_n = iter_status;
        // hyperbolic convergence needs shifts 4 and 13 executed twice
        if (is_hyp && shift_q == IW'(4) && !rep4_q)
          rep4_n = 1'b1;
        else if (is_hyp && shift_q == IW'(13) && !rep13_q)
          rep13_n = 1'b1;
        else if (shift_q != '1)
          shift_n = shift_q + IW'(1);
        if (count_inc == iter_q || abort || ov_stop) begin
          state_n = DONE;
          irq_n   = IRQ_RES || (IRQ_ERR && ov_stop);
        end
      end
      DONE: if (res_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      mode_q   <= 1'b0;
      sys_q    <= '0;
      iter_q   <= '0;
      tag_q    <= '0;
      count_q  <= '0;
      shift_q  <= '0;
      rep4_q   <= 1'b0;
      rep13_q  <= 1'b0;
      status_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_n;
      x_q      <= x_n;
      y_q      <= y_n;
      z_q      <= z_n;
      mode_q   <= mode_n;
      sys_q    <= sys_n;
      iter_q   <= iter_n;
      tag_q    <= tag_n;
      count_q  <= count_n;
      shift_q  <= shift_n;
      rep4_q   <= rep4_n;
      rep13_q  <= rep13_n;
      status_q <= status_n;
      irq_q    <= irq_n;
    end
  end

  assign job_ready  = (state_q == IDLE) && !rst;
  assign res_valid  = (state_q == DONE);
  assign res_x      = x_q;
  assign res_y      = y_q;
  assign res_z      = z_q;
  assign res_tag    = tag_q;
  assign res_iters  = count_q;
  assign res_status = status_q;
  assign irq        = irq_q;
  assign cd_x_prev  = x_q;
  assign cd_y_prev  = y_q;
  assign cd_z_prev  = z_q;
  assign cd_shift   = shift_q;
  assign cd_dir     = mode_q ? ~z_q[W-1] : y_q[W-1];
  assign cd_sys     = sys_q;
  assign cd_angle   = lut_angle;
  assign lut_offset = shift_q;
  assign lut_sys    = sys_q;

endmodule

// File: tb/tb_cordic_job_sequencer.sv
// Bench for cordic_job_sequencer: behavioural step unit and LUT, directed and random jobs
// checked against a schedule-level reference model.
module tb_cordic_job_sequencer;

  localparam logic [31:0] ATAN [0:31] = '{
    32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4, 32'h028B0D43, 32'h0145D7E1,
    32'h00A2F61E, 32'h00517C55, 32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
    32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D, 32'h000028BE, 32'h0000145F,
    32'h00000A30, 32'h00000518, 32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051,
    32'h00000029, 32'h00000014, 32'h0000000A, 32'h00000005, 32'h00000003, 32'h00000001,
    32'h00000001, 32'h00000000};

  logic clk = 1'b0;
  logic rst, job_valid, job_ready, job_mode, abort, res_valid, res_ready, irq;
  logic [31:0] job_x, job_y, job_z, res_x, res_y, res_z;
  logic [1:0]  job_sys, cd_sys, lut_sys;
  logic [4:0]  job_iter, res_iters, res_status, cd_shift, lut_offset;
  logic [3:0]  job_tag, res_tag;
  logic [31:0] cd_x_prev, cd_y_prev, cd_z_prev, cd_angle, cd_x_res, cd_y_res, cd_z_res, lut_angle;
  logic        cd_dir, cd_x_ov, cd_y_ov, cd_z_ov;

  int tests = 0;
  int fails = 0;

  logic [31:0] j_x, j_y, j_z;
  logic        j_mode;
  logic [1:0]  j_sys;
  logic [4:0]  j_iter;
  logic [3:0]  j_tag;
  int          abort_at, hold;
  bit          t5;
  logic        ovx_en, ovy_en, ovz_en;
  logic [4:0]  ovx_sh, ovy_sh, ovz_sh;

  logic [31:0] exp_x, exp_y, exp_z, exp_pre_x, exp_pre_y, exp_pre_z, cap_x, cap_z;
  int          exp_iters;
  logic [4:0]  exp_status;
  logic [4:0]  exp_shift [$];

  always #5 clk = ~clk;

  cordic_job_sequencer dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_x(job_x), .job_y(job_y), .job_z(job_z), .job_mode(job_mode), .job_sys(job_sys),
    .job_iter(job_iter), .job_tag(job_tag), .abort(abort), .res_valid(res_valid),
    .res_ready(res_ready), .res_x(res_x), .res_y(res_y), .res_z(res_z), .res_tag(res_tag),
    .res_iters(res_iters), .res_status(res_status), .irq(irq), .cd_x_prev(cd_x_prev),
    .cd_y_prev(cd_y_prev), .cd_z_prev(cd_z_prev), .cd_shift(cd_shift), .cd_dir(cd_dir),
    .cd_sys(cd_sys), .cd_angle(cd_angle), .cd_x_res(cd_x_res), .cd_y_res(cd_y_res),
    .cd_z_res(cd_z_res), .cd_x_ov(cd_x_ov), .cd_y_ov(cd_y_ov), .cd_z_ov(cd_z_ov),
    .lut_offset(lut_offset), .lut_sys(lut_sys), .lut_angle(lut_angle)
  );

  function automatic logic [31:0] lut(input logic [1:0] s, input logic [4:0] o);
    if (s == 2'b10) return 32'h40000000 >> o;
    return ATAN[o];
  endfunction

  function automatic void cstep(input logic [1:0] s, input logic d, input logic [4:0] sh,
                                input logic [31:0] ang, input logic [31:0] xi, input logic [31:0] yi,
                                input logic [31:0] zi, output logic [31:0] xo,
                                output logic [31:0] yo, output logic [31:0] zo);
    logic [31:0] xsh, ysh;
    xsh = $signed(xi) >>> sh;
    ysh = $signed(yi) >>> sh;
    xo = xi; yo = yi; zo = zi;
    case (s)
      2'b01: begin xo = d ? xi - ysh : xi + ysh; yo = d ? yi + xsh : yi - xsh; zo = d ? zi - ang : zi + ang; end
      2'b00: begin xo = d ? xi + ysh : xi - ysh; yo = d ? yi + xsh : yi - xsh; zo = d ? zi - ang : zi + ang; end
      2'b10: begin yo = d ? yi + xsh : yi - xsh; zo = d ? zi - ang : zi + ang; end
      default: ;
    endcase
  endfunction

  // external step unit and LUT
  assign lut_angle = lut(lut_sys, lut_offset);
  always_comb cstep(cd_sys, cd_dir, cd_shift, cd_angle, cd_x_prev, cd_y_prev, cd_z_prev,
                    cd_x_res, cd_y_res, cd_z_res);
  assign cd_x_ov = ovx_en && (cd_shift == ovx_sh);
  assign cd_y_ov = ovy_en && (cd_shift == ovy_sh);
  assign cd_z_ov = ovz_en && (cd_shift == ovz_sh);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: shift schedule is the natural sequence with 4 and 13 listed twice (hyperbolic)
  task automatic model();
    logic [31:0] mx, my, mz, nx, ny, nz;
    longint xs, ys, zs, ay;
    logic [4:0] sched [$];
    logic [4:0] st, k;
    bit err, stop;
    logic d;
    int n;
    for (int v = (j_sys == 2'b00) ? 1 : 0; v < 32; v++) begin
      sched.push_back(5'(v));
      if (j_sys == 2'b00 && (v == 4 || v == 13)) sched.push_back(5'(v));
    end
    exp_shift.delete();
    st = '0; n = 0;
    xs = longint'($signed(j_x)); ys = longint'($signed(j_y)); zs = longint'($signed(j_z));
    ay = (ys < 0) ? -ys : ys;
    mx = j_x; my = j_y; mz = j_z;
    if (j_sys == 2'b01 && (j_mode ? (zs > 64'sd1073741824 || zs < -64'sd1073741824) : (xs < 0))) begin
      mx = -mx; my = -my; mz[31] = ~mz[31];
    end
    exp_pre_x = mx; exp_pre_y = my; exp_pre_z = mz;
    err = (j_sys == 2'b11) || (j_iter == 0) || (j_sys == 2'b00 && (xs < 0 || ay > xs));
    st[3] = err;
    st[4] = (abort_at == 0);
    if (!err && abort_at != 0) begin
      stop = 0;
      while (!stop) begin
        k = sched[n];
        exp_shift.push_back(k);
        d = j_mode ? ~mz[31] : my[31];
        cstep(j_sys, d, k, lut(j_sys, k), mx, my, mz, nx, ny, nz);
        mx = nx; my = ny; mz = nz;
        n++;
        if (ovx_en && k == ovx_sh) st[0] = 1'b1;
        if (ovy_en && k == ovy_sh) st[1] = 1'b1;
        if (ovz_en && k == ovz_sh) st[2] = 1'b1;
        if (abort_at == n) st[4] = 1'b1;
        stop = (n == int'(j_iter)) || (abort_at == n) || (st[2:0] != 3'b000);
      end
    end
    exp_x = mx; exp_y = my; exp_z = mz;
    exp_iters = n; exp_status = st;
  endtask

  task automatic run_job();
    int edges, irqs, guard;
    bit got;
    model();
    @(negedge clk);
    job_x = j_x; job_y = j_y; job_z = j_z; job_mode = j_mode; job_sys = j_sys;
    job_iter = j_iter; job_tag = j_tag; job_valid = 1'b1; res_ready = 1'b0;
    guard = 0;
    while (!job_ready && guard < 20) begin @(negedge clk); guard++; end
    check("accept_ready", job_ready, 1);
    @(posedge clk); #1;
    job_valid = 1'b0;
    abort = (abort_at == 0);
    edges = 0; irqs = 0; got = 0;
    while (!got && edges < 80) begin
      @(posedge clk); edges++; #1;
      abort = (edges == abort_at);
      if (res_valid) got = 1;
      else if (edges <= exp_iters) begin
        if (edges == 1) begin
          cap_x = cd_x_prev; cap_z = cd_z_prev;
          check("pre_x", cd_x_prev, exp_pre_x);
          check("pre_y", cd_y_prev, exp_pre_y);
          check("pre_z", cd_z_prev, exp_pre_z);
        end
        check("shift", cd_shift, exp_shift[edges-1]);
      end
      if (irq) irqs++;
    end
    abort = 1'b0;
    check("latency", edges, exp_iters + 1);
    check("res_x", res_x, exp_x);
    check("res_y", res_y, exp_y);
    check("res_z", res_z, exp_z);
    check("res_iters", res_iters, exp_iters);
    check("res_status", res_status, exp_status);
    check("res_tag", res_tag, j_tag);
    for (int h = 0; h < hold; h++) begin
      job_valid = t5;
      @(posedge clk); #1;
      if (irq) irqs++;
      check("hold_valid", res_valid, 1);
      check("hold_ready", job_ready, 0);
      check("hold_x", res_x, exp_x);
      check("hold_status", res_status, exp_status);
    end
    job_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    if (irq) irqs++;
    check("consumed", res_valid, 0);
    check("ready_back", job_ready, 1);
    check("irq_pulses", irqs, 1);
  endtask

  task automatic set_job(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                         input logic m, input logic [1:0] s, input logic [4:0] it);
    j_x = x; j_y = y; j_z = z; j_mode = m; j_sys = s; j_iter = it;
    j_tag = 4'($urandom); abort_at = -1; hold = 0; t5 = 0;
    ovx_en = 0; ovy_en = 0; ovz_en = 0;
  endtask

  initial begin
    longint dxy;
    int cnt_v;
    rst = 1'b1; job_valid = 0; job_x = 0; job_y = 0; job_z = 0; job_mode = 0; job_sys = 0;
    job_iter = 0; job_tag = 0; abort = 0; res_ready = 0;
    ovx_en = 0; ovy_en = 0; ovz_en = 0; ovx_sh = 0; ovy_sh = 0; ovz_sh = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_job_ready", job_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_irq", irq, 0);
    check("rst_status", res_status, 0);
    check("rst_cd_x", cd_x_prev, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", job_ready, 1);

    // 45 degree rotation of a gain-compensated unit vector
    set_job(32'h26DD3B6A, 32'h0, 32'h20000000, 1, 2'b01, 16);
    run_job();
    dxy = longint'($signed(res_x)) - longint'($signed(res_y));
    check("t1_close", (dxy <= 64'sh10000 && dxy >= -64'sh10000), 1);
    check("t1_iters", res_iters, 16);

    set_job(32'h10000000, 32'h0, 32'h60000000, 1, 2'b01, 8);
    run_job();
    check("t2_z_corr", cap_z, 32'hE0000000);
    check("t2_x_corr", cap_x, 32'hF0000000);

    set_job(32'h40000000, 32'h10000000, 32'h0, 0, 2'b00, 16);
    run_job();

    set_job(32'h10000000, 32'h20000000, 32'h0, 0, 2'b00, 16);
    run_job();
    check("t4_status", res_status, 5'b01000);

    set_job(32'h30000000, 32'h0, 32'h1000000, 1, 2'b01, 12);
    hold = 10; t5 = 1;
    run_job();

    set_job(32'h20000000, 32'h0, 32'h0, 1, 2'b01, 10);
    abort_at = 3;
    run_job();
    check("t6_status", res_status, 5'b10000);
    check("t6_iters", res_iters, 3);

    set_job(32'h20000000, 32'h08000000, 32'h0, 0, 2'b10, 20);
    run_job();
    set_job(32'h20000000, 32'h0, 32'h0, 1, 2'b11, 5);
    run_job();
    set_job(32'h20000000, 32'h0, 32'h0, 1, 2'b01, 31);
    ovy_en = 1; ovy_sh = 6;
    run_job();

    // reset in the middle of a job: no result, no irq
    @(negedge clk);
    job_x = 32'h20000000; job_y = 0; job_z = 0; job_mode = 1; job_sys = 2'b01; job_iter = 20;
    job_valid = 1'b1;
    @(posedge clk); #1;
    job_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    check("midrst_ready", job_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    cnt_v = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (res_valid || irq) cnt_v++;
    end
    check("midrst_no_result", cnt_v, 0);
    check("midrst_ready_after", job_ready, 1);

    for (int r = 0; r < 40; r++) begin
      set_job($urandom, $urandom, $urandom, 1'($urandom), 2'($urandom_range(0, 2)),
              ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)));
      if ($urandom_range(0, 9) == 0) j_sys = 2'b11;
      if (j_sys == 2'b00 && $urandom_range(0, 3) != 0) begin
        j_x = {2'b00, 30'($urandom)};
        j_y = $urandom_range(0, 1) ? (j_x >> 2) : -(j_x >> 2);
        j_z = {3'b000, 29'($urandom)};
      end
      ovx_en = ($urandom_range(0, 4) == 0); ovx_sh = 5'($urandom_range(0, 20));
      ovy_en = ($urandom_range(0, 4) == 0); ovy_sh = 5'($urandom_range(0, 20));
      ovz_en = ($urandom_range(0, 4) == 0); ovz_sh = 5'($urandom_range(0, 20));
      if ($urandom_range(0, 4) == 0) abort_at = $urandom_range(0, int'(j_iter) + 1);
      hold = $urandom_range(0, 3);
      run_job();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, tests %0d", tests);
    $fatal(1, "timeout");
  end

endmodule
